// File: rtl/id_pkg.sv
// Shared decode constants for the ID stage: opcodes, instruction field positions, zero-register indices.
// Used by id_stage and id_hazard_unit; ID_STAGE_BYPASS_EN selects forwarding vs. stall-on-RAW.
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int IMM_MSB   = 15;
  localparam int FUNCT_MSB = 5;

  localparam logic [5:0] REG_ZERO_T0 = 6'd0;
  localparam logic [5:0] REG_ZERO_T1 = 6'd32;

  typedef enum logic {EXT_SIGN, EXT_ZERO} imm_ext_e;

  function automatic logic is_zero_reg(input logic [5:0] idx);
    return (idx == REG_ZERO_T0) || (idx == REG_ZERO_T1);
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic writes_rd(input logic [5:0] op);
    return !(op inside {OP_J, OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW});
  endfunction

  // Logical immediates are zero-extended so masks like 0xFFFF keep their upper half clear.
  function automatic imm_ext_e imm_ext_sel(input logic [5:0] op);
    return (op inside {OP_ANDI, OP_ORI, OP_XORI}) ? EXT_ZERO : EXT_SIGN;
  endfunction

endpackage

// File: rtl/id_hazard_unit.sv
// Combinational hazard detection for the ID stage: load-use always; with ID_STAGE_BYPASS_EN undefined,
// also stalls on any RAW against the OPR register or the M-stage write.
module id_hazard_unit
  import id_pkg::*;
#(
  parameter int RIDX = 6
) (
  input  logic            dec_valid,
  input  logic [RIDX-1:0] src0,
  input  logic [RIDX-1:0] src1,
  input  logic            opr_valid,
  input  logic [RIDX-1:0] opr_rd,
  input  logic            opr_wen,
  input  logic            opr_load,
`ifndef ID_STAGE_BYPASS_EN
  input  logic            mwrite,
  input  logic [RIDX-1:0] mwr,
`endif
  output logic            stall
);

  logic load_use;
  logic raw;

  always_comb begin
    load_use = opr_valid && opr_load && opr_wen && ((src0 == opr_rd) || (src1 == opr_rd));
    raw      = 1'b0;
`ifndef ID_STAGE_BYPASS_EN
    // Without forwarding, wait until the producer has left both OPR and M.
    raw = (opr_valid && opr_wen &&
           ((!is_zero_reg(src0) && (src0 == opr_rd)) || (!is_zero_reg(src1) && (src1 == opr_rd)))) ||
          (mwrite &&
           ((!is_zero_reg(src0) && (src0 == mwr)) || (!is_zero_reg(src1) && (src1 == mwr))));
`endif
    stall = dec_valid && (load_use || raw);
  end

endmodule

// File: rtl/id_stage.sv
// Two-stage instruction decode (DEC -> OPR) with load-use interlock and write-back snooping.
// ID_STAGE_BYPASS_EN enables M/W forwarding; otherwise RAW hazards stall DEC.
module id_stage
  import id_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RIDX = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_thread,
  output logic [RIDX-1:0] R0,
  output logic [RIDX-1:0] R1,
  input  logic [XLEN-1:0] D0,
  input  logic [XLEN-1:0] D1,
  input  logic            MWrite,
  input  logic [RIDX-1:0] MWR,
  input  logic [XLEN-1:0] MWD,
  input  logic            WWrite,
  input  logic [RIDX-1:0] WR,
  input  logic [XLEN-1:0] WD,
  input  logic            ex_ready,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [XLEN-1:0] out_imm,
  output logic [RIDX-1:0] out_rd,
  output logic            out_wen,
  output logic            out_load,
  output logic [5:0]      out_op,
  output logic [5:0]      out_funct,
  output logic [XLEN-1:0] out_pc
);

  logic            dec_valid_q, dec_valid_d;
  logic [31:0]     dec_instr_q, dec_instr_d;
  logic [XLEN-1:0] dec_pc_q, dec_pc_d;
  logic            dec_thread_q, dec_thread_d;

  logic            opr_valid_q, opr_valid_d;
  logic [XLEN-1:0] opr_a_q, opr_a_d, opr_b_q, opr_b_d, opr_imm_q, opr_imm_d, opr_pc_q, opr_pc_d;
  logic [RIDX-1:0] opr_rd_q, opr_rd_d;
  logic            opr_wen_q, opr_wen_d, opr_load_q, opr_load_d;
  logic [5:0]      opr_op_q, opr_op_d, opr_funct_q, opr_funct_d;

  logic [5:0]      dec_op;
  logic [15:0]     dec_imm16;
  logic [RIDX-1:0] dec_rd;
  logic [XLEN-1:0] dec_imm, src_a, src_b;
  logic            stall, opr_hold, dec_advance, accept;

  assign dec_op    = dec_instr_q[OP_MSB:OP_LSB];
  assign dec_imm16 = dec_instr_q[IMM_MSB:0];
  assign R0        = {dec_thread_q, dec_instr_q[RS_MSB:RS_LSB]};
  assign R1        = {dec_thread_q, dec_instr_q[RT_MSB:RT_LSB]};
  assign dec_rd    = (dec_op == OP_RTYPE) ? {dec_thread_q, dec_instr_q[RD_MSB:RD_LSB]}
                                          : {dec_thread_q, dec_instr_q[RT_MSB:RT_LSB]};
  assign dec_imm   = (imm_ext_sel(dec_op) == EXT_ZERO) ? {{(XLEN-16){1'b0}}, dec_imm16}
                                                        : {{(XLEN-16){dec_imm16[15]}}, dec_imm16};

  id_hazard_unit #(.RIDX(RIDX)) u_hazard (
    .dec_valid (dec_valid_q),
    .src0      (R0),
    .src1      (R1),
    .opr_valid (opr_valid_q),
    .opr_rd    (opr_rd_q),
    .opr_wen   (opr_wen_q),
    .opr_load  (opr_load_q),
`ifndef ID_STAGE_BYPASS_EN
    .mwrite    (MWrite),
    .mwr       (MWR),
`endif
    .stall     (stall)
  );

`ifndef ID_STAGE_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{MWD, WWrite, WR, WD};
`endif

  // Later assignments win, so the M-stage match takes priority over W.
  always_comb begin
    src_a = D0;
    src_b = D1;
`ifdef ID_STAGE_BYPASS_EN
    if (WWrite && (WR == R0)) src_a = WD;
    if (WWrite && (WR == R1)) src_b = WD;
    if (MWrite && (MWR == R0)) src_a = MWD;
    if (MWrite && (MWR == R1)) src_b = MWD;
`endif
    if (is_zero_reg(R0)) src_a = '0;
    if (is_zero_reg(R1)) src_b = '0;
  end

  assign opr_hold    = opr_valid_q && !ex_ready;
  assign dec_advance = dec_valid_q && !opr_hold && !stall;
  assign in_ready    = !dec_valid_q || dec_advance;
  assign accept      = in_valid && in_ready;

  always_comb begin
    dec_valid_d  = dec_valid_q;
    dec_instr_d  = dec_instr_q;
    dec_pc_d     = dec_pc_q;
    dec_thread_d = dec_thread_q;
    if (flush) begin
      dec_valid_d = 1'b0;
    end else if (accept) begin
      dec_valid_d  = 1'b1;
      dec_instr_d  = in_instr;
      dec_pc_d     = in_pc;
      dec_thread_d = in_thread;
    end else if (dec_advance) begin
      dec_valid_d = 1'b0;
    end
  end

  // A DEC that cannot advance while EX is ready turns into a bubble in OPR.
  always_comb begin
    opr_valid_d = opr_valid_q;
    opr_a_d     = opr_a_q;
    opr_b_d     = opr_b_q;
    opr_imm_d   = opr_imm_q;
    opr_rd_d    = opr_rd_q;
    opr_wen_d   = opr_wen_q;
    opr_load_d  = opr_load_q;
    opr_op_d    = opr_op_q;
    opr_funct_d = opr_funct_q;
    opr_pc_d    = opr_pc_q;
    if (flush || (!opr_hold && !dec_advance)) begin
      opr_valid_d = 1'b0;
      opr_wen_d   = 1'b0;
      opr_load_d  = 1'b0;
    end else if (dec_advance) begin
      opr_valid_d = 1'b1;
      opr_a_d     = src_a;
      opr_b_d     = src_b;
      opr_imm_d   = dec_imm;
      opr_rd_d    = dec_rd;
      opr_wen_d   = writes_rd(dec_op) && !is_zero_reg(dec_rd);
      opr_load_d  = is_load(dec_op);
      opr_op_d    = dec_op;
      opr_funct_d = dec_instr_q[FUNCT_MSB:0];
      opr_pc_d    = dec_pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_valid_q  <= 1'b0;
      dec_instr_q  <= '0;
      dec_pc_q     <= '0;
      dec_thread_q <= 1'b0;
      opr_valid_q  <= 1'b0;
      opr_a_q      <= '0;
      opr_b_q      <= '0;
      opr_imm_q    <= '0;
      opr_rd_q     <= '0;
      opr_wen_q    <= 1'b0;
      opr_load_q   <= 1'b0;
      opr_op_q     <= '0;
      opr_funct_q  <= '0;
      opr_pc_q     <= '0;
    end else begin
      dec_valid_q  <= dec_valid_d;
      dec_instr_q  <= dec_instr_d;
      dec_pc_q     <= dec_pc_d;
      dec_thread_q <= dec_thread_d;
      opr_valid_q  <= opr_valid_d;
      opr_a_q      <= opr_a_d;
      opr_b_q      <= opr_b_d;
      opr_imm_q    <= opr_imm_d;
      opr_rd_q     <= opr_rd_d;
      opr_wen_q    <= opr_wen_d;
      opr_load_q   <= opr_load_d;
      opr_op_q     <= opr_op_d;
      opr_funct_q  <= opr_funct_d;
      opr_pc_q     <= opr_pc_d;
    end
  end

  assign out_valid = opr_valid_q;
  assign out_a     = opr_a_q;
  assign out_b     = opr_b_q;
  assign out_imm   = opr_imm_q;
  assign out_rd    = opr_rd_q;
  assign out_wen   = opr_wen_q;
  assign out_load  = opr_load_q;
  assign out_op    = opr_op_q;
  assign out_funct = opr_funct_q;
  assign out_pc    = opr_pc_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage; expectations follow ID_STAGE_BYPASS_EN when it is defined.
module tb_id_stage;

  localparam int XLEN = 32;
  localparam int RIDX = 6;

  localparam logic [31:0] ADD_R3_R1_R2  = 32'h0022_1820;
  localparam logic [31:0] LW_R4_8_R1    = 32'h8C24_0008;
  localparam logic [31:0] ADD_R5_R4_R4  = 32'h0084_2820;
  localparam logic [31:0] ADD_R6_R9_R0  = 32'h0120_3020;
  localparam logic [31:0] ADD_R7_R0_R9  = 32'h0009_3820;
  localparam logic [31:0] ORI_R8_R1     = 32'h3428_FFFF;
  localparam logic [31:0] ADDI_R9_R1_M1 = 32'h2029_FFFF;
  localparam logic [31:0] ADD_R10_R1_R2 = 32'h0022_5020;

  logic            clk, rst_n;
  logic            in_valid, in_ready, in_thread;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic [RIDX-1:0] R0, R1;
  logic [XLEN-1:0] D0, D1;
  logic            MWrite, WWrite;
  logic [RIDX-1:0] MWR, WR;
  logic [XLEN-1:0] MWD, WD;
  logic            ex_ready, flush;
  logic            out_valid, out_wen, out_load;
  logic [XLEN-1:0] out_a, out_b, out_imm, out_pc;
  logic [RIDX-1:0] out_rd;
  logic [5:0]      out_op, out_funct;

  logic [XLEN-1:0] rf [64];
  int n_cmp  = 0;
  int n_fail = 0;

  assign D0 = rf[R0];
  assign D1 = rf[R1];

  id_stage #(.XLEN(XLEN), .RIDX(RIDX)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc), .in_thread(in_thread),
    .R0(R0), .R1(R1), .D0(D0), .D1(D1),
    .MWrite(MWrite), .MWR(MWR), .MWD(MWD), .WWrite(WWrite), .WR(WR), .WD(WD),
    .ex_ready(ex_ready), .flush(flush),
    .out_valid(out_valid), .out_a(out_a), .out_b(out_b), .out_imm(out_imm), .out_rd(out_rd),
    .out_wen(out_wen), .out_load(out_load), .out_op(out_op), .out_funct(out_funct), .out_pc(out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic [XLEN-1:0] pc, input logic thread);
    in_valid  = 1'b1;
    in_instr  = instr;
    in_pc     = pc;
    in_thread = thread;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic clearSnoop();
    MWrite = 1'b0; MWR = '0; MWD = '0;
    WWrite = 1'b0; WR  = '0; WD  = '0;
  endtask

  initial begin
    logic [31:0] exp_a, exp_b;
    for (int i = 0; i < 64; i++) rf[i] = 32'h1000 + i;
    rf[0] = 32'hDEAD_0000; rf[32] = 32'hDEAD_0020;
    rf[1] = 32'd5; rf[2] = 32'd7; rf[4] = 32'h44; rf[9] = 32'h99;
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; in_thread = 1'b0;
    ex_ready = 1'b1; flush = 1'b0;
    clearSnoop();

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_a", out_a, 32'd0);
    checkOutput("reset_out_wen", 32'(out_wen), 32'd0);

    $display("[TB] ADD r3,r1,r2 latency and operands");
    applyStimulus(ADD_R3_R1_R2, 32'h100, 1'b0);
    step();
    in_valid = 1'b0;
    checkOutput("add_R0", 32'(R0), 32'd1);
    checkOutput("add_R1", 32'(R1), 32'd2);
    checkOutput("add_cycle1_valid", 32'(out_valid), 32'd0);
    step();
    checkOutput("add_out_valid", 32'(out_valid), 32'd1);
    checkOutput("add_out_a", out_a, 32'd5);
    checkOutput("add_out_b", out_b, 32'd7);
    checkOutput("add_out_rd", 32'(out_rd), 32'd3);
    checkOutput("add_out_wen", 32'(out_wen), 32'd1);
    checkOutput("add_out_pc", out_pc, 32'h100);
    checkOutput("add_out_funct", 32'(out_funct), 32'h20);
    step();
    checkOutput("add_drain", 32'(out_valid), 32'd0);

    $display("[TB] immediate extension");
    applyStimulus(ORI_R8_R1, 32'h110, 1'b0);
    step();
    applyStimulus(ADDI_R9_R1_M1, 32'h114, 1'b0);
    step();
    in_valid = 1'b0;
    checkOutput("ori_imm", out_imm, 32'h0000_FFFF);
    checkOutput("ori_rd", 32'(out_rd), 32'd8);
    checkOutput("ori_op", 32'(out_op), 32'h0D);
    step();
    checkOutput("addi_valid", 32'(out_valid), 32'd1);
    checkOutput("addi_imm", out_imm, 32'hFFFF_FFFF);
    checkOutput("addi_rd", 32'(out_rd), 32'd9);
    step();

    $display("[TB] load-use LW r4 -> ADD r5,r4,r4");
    applyStimulus(LW_R4_8_R1, 32'h120, 1'b0);
    step();
    applyStimulus(ADD_R5_R4_R4, 32'h124, 1'b0);
    step();
    in_valid = 1'b0;
    checkOutput("lw_out_valid", 32'(out_valid), 32'd1);
    checkOutput("lw_out_load", 32'(out_load), 32'd1);
    checkOutput("lw_out_rd", 32'(out_rd), 32'd4);
    checkOutput("lw_stall_in_ready", 32'(in_ready), 32'd0);
    step();
    checkOutput("lu_bubble", 32'(out_valid), 32'd0);
    MWrite = 1'b1; MWR = 6'd4; MWD = 32'h1234;
    step();
`ifdef ID_STAGE_BYPASS_EN
    clearSnoop();
`else
    checkOutput("raw_m_bubble", 32'(out_valid), 32'd0);
    clearSnoop();
    rf[4] = 32'h1234;
    step();
`endif
    rf[4] = 32'h1234;
    checkOutput("lu_add_valid", 32'(out_valid), 32'd1);
    checkOutput("lu_add_a", out_a, 32'h1234);
    checkOutput("lu_add_b", out_b, 32'h1234);
    checkOutput("lu_add_rd", 32'(out_rd), 32'd5);
    checkOutput("lu_add_pc", out_pc, 32'h124);

    $display("[TB] snoop priority and zero register");
    applyStimulus(ADD_R6_R9_R0, 32'h130, 1'b0);
    step();
    in_valid = 1'b0;
    WWrite = 1'b1; WR = 6'd9; WD = 32'hBB;
`ifdef ID_STAGE_BYPASS_EN
    MWrite = 1'b1; MWR = 6'd9; MWD = 32'hAA;
    exp_a = 32'hAA;
`else
    exp_a = 32'h99;
`endif
    step();
    clearSnoop();
    checkOutput("prio_out_a", out_a, exp_a);
    checkOutput("prio_out_b_r0", out_b, 32'd0);
    applyStimulus(ADD_R7_R0_R9, 32'h134, 1'b0);
    step();
    in_valid = 1'b0;
    MWrite = 1'b1; MWR = 6'd0; MWD = 32'h55;
    WWrite = 1'b1; WR = 6'd9; WD = 32'hBB;
`ifdef ID_STAGE_BYPASS_EN
    exp_b = 32'hBB;
`else
    exp_b = 32'h99;
`endif
    step();
    clearSnoop();
    checkOutput("zero_valid", 32'(out_valid), 32'd1);
    checkOutput("zero_out_a", out_a, 32'd0);
    checkOutput("zero_out_b", out_b, exp_b);
    step();

    $display("[TB] ex_ready backpressure");
    applyStimulus(ADD_R3_R1_R2, 32'h200, 1'b0);
    step();
    applyStimulus(ORI_R8_R1, 32'h204, 1'b0);
    step();
    applyStimulus(ADD_R10_R1_R2, 32'h208, 1'b0);
    ex_ready = 1'b0;
    #1;
    checkOutput("bp_in_ready_full", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_hold_pc", out_pc, 32'h200);
      checkOutput("bp_hold_a", out_a, 32'd5);
      checkOutput("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    ex_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checkOutput("bp_second_pc", out_pc, 32'h204);
    checkOutput("bp_second_imm", out_imm, 32'h0000_FFFF);
    step();
    checkOutput("bp_third_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_third_pc", out_pc, 32'h208);
    checkOutput("bp_third_rd", 32'(out_rd), 32'd10);
    step();
    checkOutput("bp_no_dup", 32'(out_valid), 32'd0);

    $display("[TB] flush");
    applyStimulus(ADD_R3_R1_R2, 32'h300, 1'b0);
    step();
    applyStimulus(ORI_R8_R1, 32'h304, 1'b0);
    step();
    checkOutput("flush_pre_valid", 32'(out_valid), 32'd1);
    applyStimulus(ADD_R10_R1_R2, 32'h308, 1'b0);
    flush = 1'b1;
    ex_ready = 1'b0;
    step();
    flush = 1'b0;
    ex_ready = 1'b1;
    in_valid = 1'b0;
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      checkOutput("flush_nothing_emitted", 32'(out_valid), 32'd0);
    end

    $display("[TB] thread isolation");
    applyStimulus(LW_R4_8_R1, 32'h400, 1'b1);
    step();
    checkOutput("t1_R0", 32'(R0), 32'd33);
    applyStimulus(ADD_R5_R4_R4, 32'h404, 1'b0);
    step();
    in_valid = 1'b0;
    checkOutput("t1_lw_rd", 32'(out_rd), 32'd36);
    checkOutput("t1_lw_wen", 32'(out_wen), 32'd1);
    checkOutput("t0_add_R0", 32'(R0), 32'd4);
    checkOutput("t0_no_stall", 32'(in_ready), 32'd1);
    step();
    checkOutput("t0_add_valid", 32'(out_valid), 32'd1);
    checkOutput("t0_add_rd", 32'(out_rd), 32'd5);
    checkOutput("t0_add_a", out_a, 32'h1234);
    step();

    $display("[TB] reset mid-operation");
    applyStimulus(ADD_R3_R1_R2, 32'h500, 1'b0);
    step();
    applyStimulus(ORI_R8_R1, 32'h504, 1'b0);
    step();
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_async_pc", out_pc, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(ADD_R3_R1_R2, 32'h600, 1'b0);
    step();
    in_valid = 1'b0;
    checkOutput("rst_cycle1_valid", 32'(out_valid), 32'd0);
    step();
    checkOutput("rst_first_valid", 32'(out_valid), 32'd1);
    checkOutput("rst_first_pc", out_pc, 32'h600);
    checkOutput("rst_first_rd", 32'(out_rd), 32'd3);
    step();
    checkOutput("rst_no_stale", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameters (name, default, meaning): XLEN, 32, datapath width; RIDX, 6, register index width as {thread, reg[4:0]}.
REQ-002 SHALL have ports (name, direction, width, meaning): clk in 1 clock; rst_n in 1 asynchronous active-low reset.
REQ-003 SHALL have ports: in_valid in 1; in_ready out 1; in_instr in 32; in_pc in XLEN; in_thread in 1 (fetch handshake).
REQ-004 SHALL have ports: R0 out RIDX, R1 out RIDX (register-file read indices); D0 in XLEN, D1 in XLEN (register-file read data).
REQ-005 SHALL have ports: MWrite in 1, MWR in RIDX, MWD in XLEN, WWrite in 1, WR in RIDX, WD in XLEN (M/W write-back snoop).
REQ-006 SHALL have ports: ex_ready in 1; flush in 1; out_valid out 1; out_a out XLEN; out_b out XLEN; out_imm out XLEN; out_rd out RIDX; out_wen out 1; out_load out 1; out_op out 6; out_funct out 6; out_pc out XLEN.

Function
REQ-007 SHALL be two stages: DEC latches instruction, pc, thread and drives R0/R1 from the DEC register; OPR latches operands one cycle later; in_valid-to-out_valid latency 2 cycles absent stalls.
REQ-008 SHALL form R0 = {thread, instr[25:21]}, R1 = {thread, instr[20:16]}; out_rd = {thread, instr[15:11]} for opcode 0, else {thread, instr[20:16]}.
REQ-009 SHALL sign-extend instr[15:0] to XLEN for out_imm, except zero-extend for ANDI/ORI/XORI opcodes.
REQ-010 SHALL accept a fetch beat when in_valid && in_ready; in_ready = !DEC_valid || DEC advances this cycle.
REQ-011 SHALL hold OPR contents and out_valid stable while out_valid && !ex_ready.
REQ-012 SHALL detect load-use: DEC valid, OPR valid, out_load, out_rd nonzero and equal to R0 or R1 -> DEC holds, OPR loads a bubble (out_valid=0) for exactly one cycle.
REQ-013 SHALL select operand with priority MWR match (MWrite) over WR match (WWrite) over D0/D1; indices 0 and 32 never forwarded and always yield 0.
REQ-014 SHALL, on flush, invalidate DEC and OPR at the next clk edge; flush beats concurrent in_valid (beat discarded) and ex_ready stall.
REQ-015 SHALL treat out_rd of 0 or 32 as out_wen=0.
REQ-016 SHALL keep thread bit from in_thread unmodified through both stages; hazards compare full RIDX (different threads never conflict).

Reset
REQ-017 SHALL on rst_n low asynchronously clear DEC_valid, OPR_valid, out_valid, out_wen, out_load, and all data registers to 0; in_ready=1 after release.
REQ-018 SHALL discard any in-flight instruction when reset asserts mid-operation; first post-reset beat exits 2 cycles after acceptance.

Configuration
REQ-019 SHALL honour ID_STAGE_BYPASS_EN: defined -> REQ-013 forwarding active; undefined -> operands taken only from D0/D1, and any DEC source matching a valid OPR out_rd (out_wen) or MWR (MWrite) stalls DEC until clear (bubble inserted per stalled cycle).

Structure
REQ-020 SHALL take opcode constants, field bit positions, REG_ZERO_T0=0 and REG_ZERO_T1=32 from shared package id_pkg.
REQ-021 SHALL place hazard compare (load-use and no-bypass RAW) in combinational sub-module id_hazard_unit.

Verification
REQ-022 SHALL cover: reset release, ADD r3,r1,r2 thread0 with D0=5,D1=7 -> out_valid cycle 2, out_a=5, out_b=7, out_rd=3.
REQ-023 SHALL cover: LW r4 then ADD r5,r4,r4 back-to-back -> one bubble, ADD exits cycle 4 with operands from MWD=0x1234.
REQ-024 SHALL cover: MWR=9/MWD=0xAA and WR=9/WD=0xBB same cycle, source r9 -> out_a=0xAA; source r0 with MWR=0 -> out_a=0.
REQ-025 SHALL cover: ex_ready=0 for 3 cycles -> out_* stable, in_ready=0 after DEC full, no beat lost or duplicated.
REQ-026 SHALL cover: flush with DEC and OPR valid plus in_valid=1 -> out_valid=0 next cycle, no instruction emitted.
REQ-027 SHALL cover: thread1 LW r4 (out_rd=36) followed by thread0 ADD reading r4 (R0=4) -> no stall.
